// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer: default step
// positions, mode encoding and the step-index type.
package apu_pkg;

  localparam int COUNT_WIDTH_DEFAULT = 15;

  localparam int STEP1_DEFAULT = 3728;
  localparam int STEP2_DEFAULT = 7456;
  localparam int STEP3_DEFAULT = 11185;
  localparam int STEP4_DEFAULT = 14914;
  localparam int STEP5_DEFAULT = 18640;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  typedef logic [2:0] step_idx_t;

endpackage

// File: rtl/apu_frame_step_decoder.sv
// Combinational step decoder: maps (counter, mode) to step hit, quarter/half
// frame flags, final-step flag and the step index.
module apu_frame_step_decoder
  import apu_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int STEP1       = STEP1_DEFAULT,
  parameter int STEP2       = STEP2_DEFAULT,
  parameter int STEP3       = STEP3_DEFAULT,
  parameter int STEP4       = STEP4_DEFAULT,
  parameter int STEP5       = STEP5_DEFAULT
) (
  input  logic [COUNT_WIDTH-1:0] counter,
  input  logic                   mode,
  output logic                   step_hit,
  output logic                   quarter,
  output logic                   half,
  output logic                   final_step,
  output step_idx_t              step_idx
);

  localparam logic [COUNT_WIDTH-1:0] S1 = COUNT_WIDTH'(STEP1);
  localparam logic [COUNT_WIDTH-1:0] S2 = COUNT_WIDTH'(STEP2);
  localparam logic [COUNT_WIDTH-1:0] S3 = COUNT_WIDTH'(STEP3);
  localparam logic [COUNT_WIDTH-1:0] S4 = COUNT_WIDTH'(STEP4);
  localparam logic [COUNT_WIDTH-1:0] S5 = COUNT_WIDTH'(STEP5);

  always_comb begin
    step_hit   = 1'b0;
    half       = 1'b0;
    final_step = 1'b0;
    step_idx   = 3'd0;
    if (counter == S1) begin
      step_hit = 1'b1;
      step_idx = 3'd1;
    end else if (counter == S2) begin
      step_hit = 1'b1;
      half     = 1'b1;
      step_idx = 3'd2;
    end else if (counter == S3) begin
      step_hit = 1'b1;
      step_idx = 3'd3;
    end else if ((counter == S4) && (mode == MODE_4STEP)) begin
      step_hit   = 1'b1;
      half       = 1'b1;
      final_step = 1'b1;
      step_idx   = 3'd4;
    end else if ((counter == S5) && (mode == MODE_5STEP)) begin
      step_hit   = 1'b1;
      half       = 1'b1;
      final_step = 1'b1;
      step_idx   = 3'd5;
    end
    quarter = step_hit;
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: counts APU ticks, fires quarter/half-frame pulses and
// raises the frame IRQ. IRQ support is built only with APU_FRAME_IRQ_EN.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int STEP1       = STEP1_DEFAULT,
  parameter int STEP2       = STEP2_DEFAULT,
  parameter int STEP3       = STEP3_DEFAULT,
  parameter int STEP4       = STEP4_DEFAULT,
  parameter int STEP5       = STEP5_DEFAULT
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic       iWrite,
  input  logic [1:0] iData,
  input  logic       iIrqAck,
  output logic       oQuarterFrame,
  output logic       oHalfFrame,
  output logic       oIrq,
  output logic [2:0] oStep
);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   pend_q, pend_d;
  logic [1:0]             pend_data_q, pend_data_d;
  logic                   quarter_q, quarter_d;
  logic                   half_q, half_d;
  step_idx_t              step_q, step_d;

  logic      dec_hit, dec_quarter, dec_half, dec_final;
  step_idx_t dec_idx;
  logic      apply;
  logic      fire;

  apu_frame_step_decoder #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .STEP1       (STEP1),
    .STEP2       (STEP2),
    .STEP3       (STEP3),
    .STEP4       (STEP4),
    .STEP5       (STEP5)
  ) u_decoder (
    .counter    (cnt_q),
    .mode       (mode_q),
    .step_hit   (dec_hit),
    .quarter    (dec_quarter),
    .half       (dec_half),
    .final_step (dec_final),
    .step_idx   (dec_idx)
  );

  // A pending write takes the whole tick: it suppresses any coincident step.
  assign apply = iEnable & pend_q;
  assign fire  = iEnable & ~pend_q & dec_hit;

`ifdef APU_FRAME_IRQ_EN
  logic inh_q, inh_d;
  logic irq_q, irq_d;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    step_d      = step_q;
    quarter_d   = 1'b0;
    half_d      = 1'b0;
    pend_d      = iWrite | (pend_q & ~iEnable);
    pend_data_d = iWrite ? iData : pend_data_q;

    if (apply) begin
      cnt_d  = '0;
      mode_d = pend_data_q[1];
      step_d = 3'd0;
      if (pend_data_q[1] == MODE_5STEP) begin
        quarter_d = 1'b1;
        half_d    = 1'b1;
      end
    end else if (iEnable) begin
      cnt_d = dec_final ? '0 : cnt_q + COUNT_WIDTH'(1);
      if (fire) begin
        quarter_d = dec_quarter;
        half_d    = dec_half;
        step_d    = dec_idx;
      end else if (cnt_q == '0) begin
        step_d = 3'd0;
      end
    end

`ifdef APU_FRAME_IRQ_EN
    inh_d = apply ? pend_data_q[0] : inh_q;
    irq_d = irq_q;
    if (iIrqAck)
      irq_d = 1'b0;
    if (fire && (dec_idx == 3'd4) && !inh_q)
      irq_d = 1'b1;
    // Writing inhibit=1 drops the flag at once, not when the write applies.
    if (iWrite && iData[0])
      irq_d = 1'b0;
`endif
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      cnt_q       <= '0;
      mode_q      <= MODE_4STEP;
      pend_q      <= 1'b0;
      pend_data_q <= 2'b00;
      quarter_q   <= 1'b0;
      half_q      <= 1'b0;
      step_q      <= 3'd0;
`ifdef APU_FRAME_IRQ_EN
      inh_q       <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      quarter_q   <= quarter_d;
      half_q      <= half_d;
      step_q      <= step_d;
`ifdef APU_FRAME_IRQ_EN
      inh_q       <= inh_d;
      irq_q       <= irq_d;
`endif
    end
  end

  assign oQuarterFrame = quarter_q;
  assign oHalfFrame    = half_q;
  assign oStep         = step_q;

`ifdef APU_FRAME_IRQ_EN
  assign oIrq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = &{1'b0, iIrqAck, pend_data_q[0]};
  assign oIrq = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed, table-driven bench for apu_frame_sequencer with default step values.
module tb_apu_frame_sequencer;

`ifdef APU_FRAME_IRQ_EN
  localparam logic I = 1'b1;
`else
  localparam logic I = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iReset = 1'b1;
  logic       iEnable = 1'b0;
  logic       iWrite = 1'b0;
  logic [1:0] iData = 2'b00;
  logic       iIrqAck = 1'b0;
  logic       oQuarterFrame, oHalfFrame, oIrq;
  logic [2:0] oStep;

  apu_frame_sequencer dut (
    .iClk          (iClk),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iWrite        (iWrite),
    .iData         (iData),
    .iIrqAck       (iIrqAck),
    .oQuarterFrame (oQuarterFrame),
    .oHalfFrame    (oHalfFrame),
    .oIrq          (oIrq),
    .oStep         (oStep)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int         target;
    logic       en;
    logic       wr;
    logic [1:0] data;
    logic       ack;
    logic       eq;
    logic       eh;
    logic       eirq;
    logic [2:0] estep;
    int         next_cnt;
    string      name;
  } vec_t;

  vec_t vecs[30];
  int   nv = 0;
  int   tests = 0;
  int   fails = 0;
  int   cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int target, input logic en, input logic wr,
                     input logic [1:0] data, input logic ack, input logic eq,
                     input logic eh, input logic eirq, input logic [2:0] estep,
                     input int next_cnt, input string name);
    vecs[nv].target   = target;
    vecs[nv].en       = en;
    vecs[nv].wr       = wr;
    vecs[nv].data     = data;
    vecs[nv].ack      = ack;
    vecs[nv].eq       = eq;
    vecs[nv].eh       = eh;
    vecs[nv].eirq     = eirq;
    vecs[nv].estep    = estep;
    vecs[nv].next_cnt = next_cnt;
    vecs[nv].name     = name;
    nv++;
  endtask

  // One iClk with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic do_cycle(input logic en, input logic wr, input logic [1:0] data,
                          input logic ack);
    iEnable = en;
    iWrite  = wr;
    iData   = data;
    iIrqAck = ack;
    @(posedge iClk);
    #1;
    iEnable = 1'b0;
    iWrite  = 1'b0;
    iData   = 2'b00;
    iIrqAck = 1'b0;
  endtask

  // Plain ticks until the counter reaches target; any pulse on the way is an error.
  task automatic advance_to(input int target, input string nm);
    int spurious;
    spurious = 0;
    while (cnt < target) begin
      do_cycle(1'b1, 1'b0, 2'b00, 1'b0);
      if (oQuarterFrame || oHalfFrame) spurious++;
      cnt++;
    end
    chk({nm, "_quiet"}, spurious, 0);
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      advance_to(vecs[i].target, vecs[i].name);
      do_cycle(vecs[i].en, vecs[i].wr, vecs[i].data, vecs[i].ack);
      chk({vecs[i].name, "_quarter"}, int'(oQuarterFrame), int'(vecs[i].eq));
      chk({vecs[i].name, "_half"},    int'(oHalfFrame),    int'(vecs[i].eh));
      chk({vecs[i].name, "_irq"},     int'(oIrq),          int'(vecs[i].eirq));
      chk({vecs[i].name, "_step"},    int'(oStep),         int'(vecs[i].estep));
      cnt = vecs[i].next_cnt;
    end
  endtask

  initial begin
    //  target  en wr data  ack  q  h  irq  step next   name
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "m0_s1");
    add(7456,  1, 0, 2'b00, 0,  1, 1, 0, 3'd2, 7457,  "m0_s2");
    add(11185, 1, 0, 2'b00, 0,  1, 0, 0, 3'd3, 11186, "m0_s3");
    add(14914, 1, 0, 2'b00, 0,  1, 1, I, 3'd4, 0,     "m0_s4");
    add(0,     1, 0, 2'b00, 0,  0, 0, I, 3'd0, 1,     "m0_wrap");
    add(1,     0, 0, 2'b00, 1,  0, 0, 0, 3'd0, 1,     "irq_ack");
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "f2_s1");
    add(7456,  1, 0, 2'b00, 0,  1, 1, 0, 3'd2, 7457,  "f2_s2");
    add(11185, 1, 0, 2'b00, 0,  1, 0, 0, 3'd3, 11186, "f2_s3");
    add(14914, 1, 0, 2'b00, 1,  1, 1, I, 3'd4, 0,     "set_beats_ack");
    add(0,     0, 1, 2'b01, 0,  0, 0, 0, 3'd4, 0,     "inhibit_clear");
    add(0,     1, 0, 2'b00, 0,  0, 0, 0, 3'd0, 0,     "m0_apply_quiet");
    add(0,     0, 1, 2'b10, 0,  0, 0, 0, 3'd0, 0,     "m1_pending");
    add(0,     1, 0, 2'b00, 0,  1, 1, 0, 3'd0, 0,     "m1_immediate");
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "m1_s1");
    add(7456,  1, 0, 2'b00, 0,  1, 1, 0, 3'd2, 7457,  "m1_s2");
    add(11185, 1, 0, 2'b00, 0,  1, 0, 0, 3'd3, 11186, "m1_s3");
    add(14914, 1, 0, 2'b00, 0,  0, 0, 0, 3'd3, 14915, "m1_no_s4");
    add(18640, 1, 0, 2'b00, 0,  1, 1, 0, 3'd5, 0,     "m1_s5");
    add(0,     1, 0, 2'b00, 0,  0, 0, 0, 3'd0, 1,     "m1_wrap");
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "m1b_s1");
    add(7456,  1, 0, 2'b00, 0,  1, 1, 0, 3'd2, 7457,  "m1b_s2");
    // after the mid-frame reset
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "post_reset_s1");
    add(7455,  1, 1, 2'b00, 0,  0, 0, 0, 3'd1, 7456,  "wr_at_7455");
    add(7456,  1, 0, 2'b00, 0,  0, 0, 0, 3'd0, 0,     "write_beats_s2");
    add(0,     1, 0, 2'b00, 0,  0, 0, 0, 3'd0, 1,     "restart");
    add(3728,  1, 0, 2'b00, 0,  1, 0, 0, 3'd1, 3729,  "restart_s1");
    add(3729,  0, 1, 2'b10, 0,  0, 0, 0, 3'd1, 3729,  "pend_first");
    add(3729,  0, 1, 2'b00, 0,  0, 0, 0, 3'd1, 3729,  "pend_replace");
    add(3729,  1, 0, 2'b00, 0,  0, 0, 0, 3'd0, 0,     "last_write_wins");

    // Reset held with ticks present: everything stays at zero.
    repeat (3) begin
      do_cycle(1'b1, 1'b1, 2'b10, 1'b0);
      chk("rst_hold_quarter", int'(oQuarterFrame), 0);
      chk("rst_hold_half",    int'(oHalfFrame),    0);
      chk("rst_hold_irq",     int'(oIrq),          0);
      chk("rst_hold_step",    int'(oStep),         0);
    end
    iReset = 1'b0;
    cnt = 0;

    run_vecs(0, 21);

    // Abort a mode-1 frame at counter 9000; step index 2 must drop asynchronously.
    advance_to(9000, "to_9000");
    chk("pre_reset_step", int'(oStep), 2);
    #2;
    iReset = 1'b1;
    #1;
    chk("async_rst_quarter", int'(oQuarterFrame), 0);
    chk("async_rst_half",    int'(oHalfFrame),    0);
    chk("async_rst_irq",     int'(oIrq),          0);
    chk("async_rst_step",    int'(oStep),         0);
    repeat (2) do_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    chk("rst_mid_step", int'(oStep), 0);
    iReset = 1'b0;
    cnt = 0;

    run_vecs(22, 29);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apu_frame_sequencer.md
APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 15: width of the APU-cycle frame counter.
REQ-002 Parameters STEP1..STEP5, defaults 3728/7456/11185/14914/18640: counter values at which frame steps fire.
REQ-003 iClk  input  1  system clock; all state is sampled on its rising edge.
REQ-004 iReset  input  1  reset, asynchronous, active-high.
REQ-005 iEnable  input  1  APU-cycle tick (one iClk wide); the counter advances only on ticks.
REQ-006 iWrite  input  1  one-cycle strobe for a frame-control register write ($4017).
REQ-007 iData  input  2  write data: bit1 = mode (0 = 4-step, 1 = 5-step), bit0 = IRQ inhibit.
REQ-008 iIrqAck  input  1  one-cycle strobe for a status read; clears the frame IRQ flag.
REQ-009 oQuarterFrame  output  1  one-iClk pulse that clocks the envelope and linear-counter units.
REQ-010 oHalfFrame  output  1  one-iClk pulse that clocks the length-counter and sweep units.
REQ-011 oIrq  output  1  frame IRQ flag (level).
REQ-012 oStep  output  3  index of the last fired step (0 = none since wrap, 1..5).

Function
REQ-013 The counter SHALL increment by 1 on each iEnable tick and SHALL hold otherwise.
REQ-014 Step k SHALL fire on the tick where the counter equals STEPk.
- Mode 0 uses steps 1-4.
- Mode 1 uses steps 1, 2, 3 and 5.
REQ-015 oQuarterFrame SHALL pulse on every fired step.
REQ-016 oHalfFrame SHALL pulse on step 2 and on the final step (4 in mode 0, 5 in mode 1).
REQ-017 On the final step the counter SHALL load 0 instead of incrementing; oStep SHALL read the final step index for that cycle, then 0 after the next tick.
REQ-018 Pulse latency: every output pulse SHALL be registered, asserted in the iClk cycle after the triggering tick, and exactly one iClk wide.
REQ-019 A write SHALL be captured into a pending register and applied on the next iEnable tick:
- mode and inhibit are latched;
- the counter is cleared to 0;
- oStep is cleared to 0.
REQ-020 When an applied write has mode 1, one oQuarterFrame and one oHalfFrame pulse SHALL be issued immediately, with the latency of REQ-018.
REQ-021 When an applied write has mode 0, no pulse SHALL be issued.
REQ-022 If a write is applied on a tick that also matches a step, the write SHALL win and that step SHALL NOT fire.
REQ-023 If a second write arrives while one is pending, the later data SHALL replace the pending data.
REQ-024 oIrq SHALL set when mode 0 reaches step 4 and inhibit is 0.
REQ-025 oIrq SHALL clear on iIrqAck, or immediately (same iClk) when iWrite carries inhibit = 1.
REQ-026 If an IRQ set coincides with iIrqAck, the set SHALL win.
REQ-027 Mode 1 SHALL never set oIrq.
REQ-028 A counter match at a value above the active final step SHALL NOT be possible; the counter never exceeds the final step.

Reset
REQ-029 While iReset is high, the block SHALL hold:
- counter = 0, mode = 0, inhibit = 0;
- pending write cleared;
- oQuarterFrame = 0, oHalfFrame = 0, oIrq = 0, oStep = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release, counting SHALL resume from 0 in mode 0.

Configuration
REQ-031 With macro APU_FRAME_IRQ_EN defined, the IRQ flag, the inhibit bit and iIrqAck handling SHALL be implemented.
REQ-032 Without APU_FRAME_IRQ_EN, oIrq SHALL be constant 0, inhibit SHALL be ignored, iIrqAck SHALL be unused, and all other behaviour SHALL be unchanged.

Structure
REQ-033 Shared package apu_pkg SHALL hold:
- the STEP1..STEP5 default constants;
- the mode encoding constants (MODE_4STEP = 0, MODE_5STEP = 1);
- the step-index typedef (3 bits).
REQ-034 Sub-module apu_frame_step_decoder SHALL be purely combinational and SHALL map (counter, mode) to step-hit, quarter-frame, half-frame and final-step flags.
REQ-035 All sequencing and registers SHALL stay in the top module.

Verification
REQ-036 Reset, then a continuous tick on every iClk in mode 0 -> oQuarterFrame at counter 3728/7456/11185/14914, oHalfFrame at 7456/14914, oIrq set after 14914, counter wraps to 0.
REQ-037 Write iData = 2'b10, then ticks -> immediate quarter + half pulses one cycle after the applying tick; steps at 3728/7456/11185/18640; half at 7456/18640; oIrq never set.
REQ-038 oIrq set, then iIrqAck -> oIrq = 0 next cycle; iIrqAck coincident with a step-4 set -> oIrq stays 1.
REQ-039 Write coincident with counter = 7455 and a tick pending -> no step-2 pulse, counter restarts at 0, oStep = 0.
REQ-040 iReset asserted at counter = 9000 in mode 1 -> all outputs 0 immediately; after release, mode 0 and the first pulse at 3728 ticks.
REQ-041 Build without APU_FRAME_IRQ_EN and repeat REQ-036 -> identical pulses, oIrq constant 0.
